// File: rtl/circuit_lut.sv
// Circuit labelling over sorted junction-point pairs. Each accepted pair merges the
// circuits of its two points. After NUM_CONNS pairs the sizes are scanned for the top three.
module circuit_lut #(
  parameter  int NUM_POINTS = 1000,
  parameter  int NUM_CONNS  = 1000,
  localparam int IDX_W      = $clog2(NUM_POINTS),
  localparam int SIZE_W     = $clog2(NUM_POINTS + 1),
  localparam int PROD_W     = 3 * SIZE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  pointa_in,
  input  logic [IDX_W-1:0]  pointb_in,
  input  logic              points_vld,
  output logic [PROD_W-1:0] result,
  output logic              result_vld,
  output logic              busy,
  output logic              overflow
);

  localparam int CNT_W = $clog2(NUM_CONNS + 1);

  typedef enum logic [1:0] {ACCUM, SCAN, MULT, DONE} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    label_q [NUM_POINTS];
  logic [IDX_W-1:0]    label_d [NUM_POINTS];
  logic [SIZE_W-1:0]   size_q  [NUM_POINTS];
  logic [SIZE_W-1:0]   size_d  [NUM_POINTS];
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    scan_q;
  logic [SIZE_W-1:0]   top1_q, top2_q, top3_q;
  logic [PROD_W-1:0]   result_q;
  logic                result_vld_q, busy_q, overflow_q;

  logic                accept;
  logic [IDX_W-1:0]    la, lb;
  logic [SIZE_W-1:0]   scan_size;

  assign result     = result_q;
  assign result_vld = result_vld_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;

  // Whole-array relabel in one cycle so a dependent pair on the next cycle sees the merge.
  always_comb begin
    accept    = (state_q == ACCUM) && points_vld;
    la        = label_q[pointa_in];
    lb        = label_q[pointb_in];
    scan_size = size_q[scan_q];
    label_d   = label_q;
    size_d    = size_q;
    if (accept && (la != lb)) begin
      for (int unsigned i = 0; i < NUM_POINTS; i++) begin
        if (label_q[i] == lb) label_d[i] = la;
      end
      size_d[la] = size_q[la] + size_q[lb];
      size_d[lb] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_POINTS; i++) begin
        label_q[i] <= IDX_W'(i);
        size_q[i]  <= SIZE_W'(1);
      end
      state_q      <= ACCUM;
      cnt_q        <= '0;
      scan_q       <= '0;
      top1_q       <= '0;
      top2_q       <= '0;
      top3_q       <= '0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      label_q <= label_d;
      size_q  <= size_d;
      if (points_vld && (state_q != ACCUM)) overflow_q <= 1'b1;
      case (state_q)
        ACCUM: begin
          if (points_vld) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(NUM_CONNS - 1)) begin
              state_q <= SCAN;
              scan_q  <= '0;
              top1_q  <= '0;
              top2_q  <= '0;
              top3_q  <= '0;
              busy_q  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (scan_size > top1_q) begin
            top1_q <= scan_size;
            top2_q <= top1_q;
            top3_q <= top2_q;
          end else if (scan_size > top2_q) begin
            top2_q <= scan_size;
            top3_q <= top2_q;
          end else if (scan_size > top3_q) begin
            top3_q <= scan_size;
          end
          if (scan_q == IDX_W'(NUM_POINTS - 1)) state_q <= MULT;
          else                                  scan_q  <= scan_q + 1'b1;
        end
        MULT: begin
          result_q     <= PROD_W'(top1_q) * PROD_W'(top2_q) * PROD_W'(top3_q);
          result_vld_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= DONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_circuit_lut.sv
// Scoreboard bench for circuit_lut: a union-find reference model predicts each result,
// and per-instance monitors pop and compare when result_vld first rises.
module tb_circuit_lut;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 1: 8 points, 4 pairs
  logic        rst1 = 1'b0, vld1 = 1'b0;
  logic [2:0]  a1 = '0, b1 = '0;
  logic [11:0] res1;
  logic        rv1, busy1, ovf1;

  // Instance 2: 20 points, 10 pairs
  logic        rst2 = 1'b0, vld2 = 1'b0;
  logic [4:0]  a2 = '0, b2 = '0;
  logic [14:0] res2;
  logic        rv2, busy2, ovf2;

  circuit_lut #(.NUM_POINTS(8), .NUM_CONNS(4)) dut1 (
    .clk(clk), .rst(rst1), .pointa_in(a1), .pointb_in(b1), .points_vld(vld1),
    .result(res1), .result_vld(rv1), .busy(busy1), .overflow(ovf1));

  circuit_lut #(.NUM_POINTS(20), .NUM_CONNS(10)) dut2 (
    .clk(clk), .rst(rst2), .pointa_in(a2), .pointb_in(b2), .points_vld(vld2),
    .result(res2), .result_vld(rv2), .busy(busy2), .overflow(ovf2));

  int     n_cmp = 0, n_fail = 0;
  longint exp1_q[$], exp2_q[$];
  int     last1 = 0, last2 = 0;
  bit     seen1 = 0, seen2 = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: union-find over the pairs, then sort circuit sizes descending.
  function automatic longint model(input int n, input int pa[$], input int pb[$]);
    int par[]; int sz[]; int sizes[$]; int ra, rb;
    par = new[n]; sz = new[n];
    for (int i = 0; i < n; i++) begin par[i] = i; sz[i] = 0; end
    for (int k = 0; k < pa.size(); k++) begin
      ra = pa[k]; while (par[ra] != ra) ra = par[ra];
      rb = pb[k]; while (par[rb] != rb) rb = par[rb];
      if (ra != rb) par[rb] = ra;
    end
    for (int i = 0; i < n; i++) begin
      ra = i; while (par[ra] != ra) ra = par[ra];
      sz[ra]++;
    end
    for (int i = 0; i < n; i++) if (sz[i] > 0) sizes.push_back(sz[i]);
    sizes.rsort();
    if (sizes.size() < 3) return 0;
    return longint'(sizes[0]) * sizes[1] * sizes[2];
  endfunction

  initial forever begin
    @(negedge clk);
    if (!rst1 && rv1 && !seen1) begin
      seen1 = 1;
      if (exp1_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_result1: got %0d expected no result", res1);
      end else begin
        check("result1", res1, exp1_q.pop_front());
        check("latency1", cyc - last1, 9);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst2 && rv2 && !seen2) begin
      seen2 = 1;
      if (exp2_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_result2: got %0d expected no result", res2);
      end else begin
        check("result2", res2, exp2_q.pop_front());
        check("latency2", cyc - last2, 21);
      end
    end
  end

  task automatic reset1();
    @(negedge clk); vld1 = 0; rst1 = 1;
    @(negedge clk); seen1 = 0;
    @(negedge clk); rst1 = 0;
  endtask

  task automatic reset2();
    @(negedge clk); vld2 = 0; rst2 = 1;
    @(negedge clk); seen2 = 0;
    @(negedge clk); rst2 = 0;
  endtask

  task automatic send1(input int a, input int b);
    @(negedge clk); a1 = 3'(a); b1 = 3'(b); vld1 = 1;
  endtask

  task automatic send2(input int a, input int b);
    @(negedge clk); a2 = 5'(a); b2 = 5'(b); vld2 = 1;
  endtask

  task automatic wait1(input int budget);
    int t = 0;
    while (!seen1 && t < budget) begin @(negedge clk); t++; end
    if (!seen1) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout1: got no result_vld expected within %0d cycles", budget);
    end
  endtask

  task automatic wait2(input int budget);
    int t = 0;
    while (!seen2 && t < budget) begin @(negedge clk); t++; end
    if (!seen2) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout2: got no result_vld expected within %0d cycles", budget);
    end
  endtask

  // Issue 4 pairs with gap[i] idle cycles after pair i, predicting the result up front.
  task automatic run1(input int pa[4], input int pb[4], input int gap[4]);
    int qa[$], qb[$];
    for (int i = 0; i < 4; i++) begin qa.push_back(pa[i]); qb.push_back(pb[i]); end
    exp1_q.push_back(model(8, qa, qb));
    for (int i = 0; i < 4; i++) begin
      send1(pa[i], pb[i]);
      if (i < 3) repeat (gap[i]) begin @(negedge clk); vld1 = 0; end
    end
    @(negedge clk); vld1 = 0; last1 = cyc;
    check("busy_scan1", busy1, 1);
    wait1(40);
  endtask

  int xs[20] = '{162, 57, 906, 592, 352, 466, 542, 431, 739, 52,
                 216, 819, 117, 805, 346, 970, 941, 862, 984, 425};
  int ys[20] = '{817, 618, 360, 479, 342, 668, 29, 825, 650, 470,
                 146, 987, 168, 96, 949, 615, 993, 61, 92, 690};
  int zs[20] = '{812, 57, 560, 940, 300, 158, 236, 988, 466, 668,
                 977, 18, 530, 715, 466, 88, 340, 35, 344, 689};

  initial begin
    int     pa[4], pb[4], gp[4];
    int     qa[$], qb[$];
    bit     used[20][20];
    longint d, best;
    int     bi, bj;

    reset1();
    reset2();
    @(negedge clk);
    check("rst_result", res1, 0);
    check("rst_vld", rv1, 0);
    check("rst_busy", busy1, 0);
    check("rst_ovf", ovf1, 0);
    check("rst_vld2", rv2, 0);

    // Back-to-back pairs including a self pair
    pa = '{0, 1, 3, 5}; pb = '{1, 2, 4, 5}; gp = '{0, 0, 0, 0};
    run1(pa, pb, gp);
    check("done_busy", busy1, 0);
    // Pairs after completion only raise overflow
    send1(0, 7); send1(6, 7);
    @(negedge clk); vld1 = 0;
    @(negedge clk);
    check("late_ovf", ovf1, 1);
    check("late_result", res1, 6);
    check("late_vld", rv1, 1);

    // Redundant pairs with gaps
    reset1();
    pa = '{0, 1, 0, 2}; pb = '{1, 0, 1, 3}; gp = '{3, 3, 3, 0};
    run1(pa, pb, gp);
    check("redundant_ovf", ovf1, 0);

    // Transitive relabel on consecutive cycles
    reset1();
    pa = '{0, 2, 1, 4}; pb = '{1, 3, 3, 5}; gp = '{0, 0, 0, 0};
    run1(pa, pb, gp);

    // Reset after two pairs discards their merges
    reset1();
    send1(0, 7); send1(6, 7);
    @(negedge clk); vld1 = 0;
    reset1();
    pa = '{0, 1, 3, 5}; pb = '{1, 2, 4, 5}; gp = '{0, 0, 0, 0};
    run1(pa, pb, gp);

    // Reset in the middle of the scan
    reset1();
    send1(0, 1); send1(2, 3); send1(4, 5); send1(6, 7);
    @(negedge clk); vld1 = 0;
    repeat (3) @(negedge clk);
    check("midscan_busy", busy1, 1);
    reset1();
    @(negedge clk);
    check("midscan_rst_busy", busy1, 0);
    check("midscan_rst_vld", rv1, 0);
    pa = '{0, 2, 1, 4}; pb = '{1, 3, 3, 5}; gp = '{0, 0, 0, 0};
    run1(pa, pb, gp);

    // Randomized pairs and gaps
    for (int r = 0; r < 12; r++) begin
      reset1();
      for (int i = 0; i < 4; i++) begin
        pa[i] = $urandom_range(0, 7);
        pb[i] = $urandom_range(0, 7);
        gp[i] = $urandom_range(0, 3);
      end
      run1(pa, pb, gp);
      check("rand_ovf", ovf1, 0);
    end

    // AoC example: ten closest pairs by Euclidean distance
    for (int i = 0; i < 20; i++) for (int j = 0; j < 20; j++) used[i][j] = 0;
    for (int k = 0; k < 10; k++) begin
      best = -1; bi = 0; bj = 0;
      for (int i = 0; i < 20; i++)
        for (int j = i + 1; j < 20; j++) begin
          d = longint'(xs[i] - xs[j]) * (xs[i] - xs[j]) +
              longint'(ys[i] - ys[j]) * (ys[i] - ys[j]) +
              longint'(zs[i] - zs[j]) * (zs[i] - zs[j]);
          if (!used[i][j] && (best < 0 || d < best)) begin best = d; bi = i; bj = j; end
        end
      used[bi][bj] = 1;
      qa.push_back(bi); qb.push_back(bj);
    end
    exp2_q.push_back(40);
    for (int k = 0; k < 10; k++) send2(qa[k], qb[k]);
    @(negedge clk); vld2 = 0; last2 = cyc;
    wait2(60);
    check("aoc_ovf", ovf2, 0);

    // Random pairs on the larger instance
    reset2();
    qa.delete(); qb.delete();
    for (int k = 0; k < 10; k++) begin
      qa.push_back($urandom_range(0, 19)); qb.push_back($urandom_range(0, 19));
    end
    exp2_q.push_back(model(20, qa, qb));
    for (int k = 0; k < 10; k++) send2(qa[k], qb[k]);
    @(negedge clk); vld2 = 0; last2 = cyc;
    wait2(60);

    repeat (2) @(negedge clk);
    check("sb_empty1", exp1_q.size(), 0);
    check("sb_empty2", exp2_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
